// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem req/ack, prefetch queue toward IF/ID
// One outstanding request; DISCARD swallows the reply of a request orphaned by a redirect.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        IFID_enable,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        inst_valid,
  output logic [15:0] instOut,
  output logic [15:0] pcAddOut
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   fetch_pc;
  logic [15:0]   hold_addr;
  logic [15:0]   q_inst [QDEPTH];
  logic [15:0]   q_pc   [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          push;
  logic          pop;

  assign inst_valid  = (count != '0);
  assign pop         = inst_valid & IFID_enable;
  assign push        = (state == REQ) & imem_ack & ~redirect;
  assign count_after = count + CW'(push) - CW'(pop);
  assign instOut     = q_inst[head];
  assign pcAddOut    = q_pc[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (redirect || (count < DEPTH)) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          state_nx = imem_ack ? REQ : DISCARD;
        end else if (imem_ack) begin
          state_nx = (count_after < DEPTH) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = (state == DISCARD) ? hold_addr : fetch_pc;
  end

  // Redirect flushes the queue and wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_target & 16'hFFFE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      if ((state == REQ) && !imem_ack) begin
        hold_addr <= fetch_pc;
      end
    end else begin
      if (push) begin
        q_inst[tail] <= imem_data;
        q_pc[tail]   <= fetch_pc + 16'd2;
        tail         <= tail + PW'(1);
        fetch_pc     <= fetch_pc + 16'd2;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_after;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a variable-latency memory model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        IFID_enable;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        inst_valid;
  logic [15:0] instOut;
  logic [15:0] pcAddOut;

  int mem_lat = 0;
  int wcnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] sb[$];
  logic [31:0] sb_e;
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] hold = 16'h0000;
  bit          pending = 1'b0;
  bit          prev_wait = 1'b0;

  always #5 clk = ~clk;

  // Memory replies after mem_lat waiting cycles; data derived from the address.
  assign imem_ack  = imem_req && (wcnt >= mem_lat);
  assign imem_data = imem_addr ^ 16'hA000;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  if_fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .IFID_enable(IFID_enable),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .inst_valid(inst_valid),
    .instOut(instOut),
    .pcAddOut(pcAddOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of the expected fetch stream, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_pc = 16'h0000;
      pending = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) check("req_held", {31'd0, imem_req}, 32'd1);
      if (imem_req) check("req_addr", {16'd0, imem_addr}, {16'd0, pending ? hold : exp_pc});
      check("valid_vs_model", {31'd0, inst_valid}, {31'd0, sb.size() != 0});
      if (inst_valid && IFID_enable && !redirect && sb.size() != 0) begin
        sb_e = sb.pop_front();
        check("instOut", {16'd0, instOut}, {16'd0, sb_e[31:16]});
        check("pcAddOut", {16'd0, pcAddOut}, {16'd0, sb_e[15:0]});
      end
      if (redirect) begin
        if (imem_req && !imem_ack && !pending) begin
          pending = 1'b1;
          hold = exp_pc;
        end else if (imem_ack) begin
          pending = 1'b0;
        end
        sb.delete();
        exp_pc = redirect_target & 16'hFFFE;
      end else if (imem_ack) begin
        if (pending) pending = 1'b0;
        else begin
          sb.push_back({exp_pc ^ 16'hA000, exp_pc + 16'd2});
          exp_pc = exp_pc + 16'd2;
        end
      end
      prev_wait = imem_req && !imem_ack;
    end
  end

  initial begin
    int  acks;
    bit  seen;
    reset = 1'b1;
    IFID_enable = 1'b1;
    redirect = 1'b0;
    redirect_target = 16'h0000;
    step(2);
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", {16'd0, instOut}, 32'd0);
    check("rst_pcadd", {16'd0, pcAddOut}, 32'd0);
    check("rst_addr", {16'd0, imem_addr}, 32'd0);

    // 1: zero-wait streaming
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_ack) seen = 1;
    end
    check("first_ack_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("first_valid", {31'd0, inst_valid}, 32'd1);
    check("first_inst", {16'd0, instOut}, 32'h0000A000);
    check("first_pcadd", {16'd0, pcAddOut}, 32'h00000002);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_ack) acks++;
    end
    check("zero_wait_rate", acks, 6);

    // 2: stall fills the queue and holds the head
    @(posedge clk); #1;
    IFID_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        check("stall_inst", {16'd0, instOut}, {16'd0, sb[0][31:16]});
        check("stall_pcadd", {16'd0, pcAddOut}, {16'd0, sb[0][15:0]});
      end
    end
    check("stall_req_drop", {31'd0, imem_req}, 32'd0);
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    @(posedge clk); #1;
    IFID_enable = 1'b1;
    step(8);

    // 3: redirect while a slow request to 0x0006 is outstanding
    reset = 1'b1;
    mem_lat = 3;
    step(1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h0006 && wcnt == 0) seen = 1;
    end
    check("reach_addr6", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_target = 16'h0041;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("redir_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_hold_addr", {16'd0, imem_addr}, 32'h00000006);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr != 16'h0006) seen = 1;
    end
    check("redir_new_addr", {16'd0, imem_addr}, 32'h00000040);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1;
    end
    check("redir_first_pcadd", {16'd0, pcAddOut}, 32'h00000042);
    check("redir_first_inst", {16'd0, instOut}, 32'h0000A040);

    // 4: redirect coincident with ack and pop
    mem_lat = 0;
    step(3);
    @(negedge clk);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_target = 16'h0100;
    @(negedge clk);
    check("coinc_ack", {31'd0, imem_ack}, 32'd1);
    check("coinc_pop", {31'd0, inst_valid}, 32'd1);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("coinc_empty", {31'd0, inst_valid}, 32'd0);
    check("coinc_addr", {16'd0, imem_addr}, 32'h00000100);
    step(4);

    // 5: wrap at 0xFFFE
    redirect = 1'b1;
    redirect_target = 16'hFFFE;
    @(posedge clk); #1;
    redirect = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1;
    end
    check("wrap_pcadd", {16'd0, pcAddOut}, 32'h00000000);
    check("wrap_inst", {16'd0, instOut}, 32'h00005FFE);
    check("wrap_next_addr", {16'd0, imem_addr}, 32'h00000000);
    step(5);

    // 6: reset while discarding, after the queue had filled
    IFID_enable = 1'b0;
    step(4);
    mem_lat = 4;
    redirect = 1'b1;
    redirect_target = 16'h0200;
    @(posedge clk); #1;
    redirect_target = 16'h0300;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("disc_addr", {16'd0, imem_addr}, 32'h00000200);
    check("disc_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_lat = 0;
    IFID_enable = 1'b1;
    @(negedge clk);
    check("rst6_req", {31'd0, imem_req}, 32'd0);
    check("rst6_valid", {31'd0, inst_valid}, 32'd0);
    check("rst6_inst", {16'd0, instOut}, 32'd0);
    check("rst6_pcadd", {16'd0, pcAddOut}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1;
    end
    check("rst6_restart_addr", {15'd0, seen, imem_addr}, 32'h00010000);
    step(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: producer side of the IF/ID interface.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch queue and presents {instOut, pcAddOut, inst_valid} to IFID_Buffer.
- Honors IFID_enable (stall) and redirect/flush (branch or jump) from the ID/EX hazard logic.

Parameters:
RESET_PC  16'h0000  fetch address after reset; LSB must be 0
QDEPTH    2         prefetch queue entries (power of 2, >=2)

Ports:
clk              input   1   rising-edge clock
reset            input   1   synchronous, active-high reset
imem_req         output  1   fetch request; held until imem_ack
imem_addr        output  16  fetch address; stable while imem_req=1
imem_ack         input   1   memory completes request this cycle; may assert in first req cycle
imem_data        input   16  instruction word, valid when imem_ack=1
IFID_enable      input   1   1 = IF/ID buffer accepts head entry this cycle; 0 = stall
redirect         input   1   flush fetch and restart at redirect_target
redirect_target  input   16  new PC; bit 0 ignored (forced 0)
inst_valid       output  1   queue non-empty; head entry is presented
instOut          output  16  head instruction
pcAddOut         output  16  head instruction address + 2

Behaviour:
- Reset (sampled at clk edge):
  - fetch_pc=RESET_PC, queue empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, instOut=0, pcAddOut=0.
  - Reset beats redirect, ack and pop.
- FSM states:
  - IDLE -> REQ when count<QDEPTH.
  - REQ (imem_req=1, imem_addr=fetch_pc):
    - on imem_ack: push {fetch_pc+2, imem_data}; fetch_pc+=2.
    - After ack: stay in REQ if count_after<QDEPTH, else IDLE.
  - DISCARD (imem_req=1, old address held):
    - on imem_ack: drop data, go to REQ at the already-loaded target.
- Only one request outstanding. imem_req never drops and imem_addr never changes before imem_ack.
- Throughput: with zero-wait memory (ack in first req cycle) and IFID_enable=1, one instruction per cycle.
- First req is asserted the cycle after reset deasserts.
- Queue output:
  - inst_valid=(count!=0); instOut/pcAddOut show the head entry combinationally from queue storage.
  - Pop when inst_valid & IFID_enable.
  - Push and pop in the same cycle leave count unchanged.
  - IFID_enable=0 holds the head and all outputs stable.
- Full: new requests start only while count<QDEPTH. An in-flight ack always has space, so there is no overflow.
- Redirect (one-cycle pulse), priority over push/pop:
  - Queue cleared at the same edge, so inst_valid=0 next cycle.
  - fetch_pc <= {redirect_target[15:1],1'b0}.
  - If REQ with no ack this cycle: go to DISCARD.
  - If ack this cycle: data dropped, go to REQ at target.
  - If IDLE: go to REQ.
  - Redirect in DISCARD: update target, remain in DISCARD.
- Arithmetic: 16-bit, wraps modulo 2^16. PC 16'hFFFE gives pcAddOut 16'h0000, next fetch at 16'h0000.
- Reset mid-transaction: request abandoned, imem_req=0 the next cycle. The memory model must tolerate the abandoned request.

Test Plan:
1. Reset then release, zero-wait mem returning data=addr^16'hA000, IFID_enable=1:
   - imem_addr 0,2,4,... on consecutive cycles.
   - inst_valid rises 1 cycle after first ack.
   - Outputs (instOut,pcAddOut) = (A000,0002), (A002,0004), ...
2. Stall: IFID_enable=0 for 5 cycles mid-stream:
   - Queue fills to 2; imem_req drops.
   - instOut/pcAddOut stay constant.
   - On release, entries drain in order with no loss or duplication.
3. Redirect to 16'h0041 while 3-cycle-latency request to 0x0006 outstanding:
   - inst_valid=0 next cycle; addr held at 0x0006 until ack; its data discarded.
   - Next req addr=0x0040; first output pcAddOut=0x0042.
4. Redirect coincident with imem_ack and a pop:
   - Acked word not enqueued; queue empty next cycle.
   - Next req at target.
5. Wrap: redirect to 16'hFFFE:
   - Outputs pcAddOut=0x0000; next fetch addr=0x0000.
6. Reset asserted while in DISCARD with queue full:
   - Next cycle imem_req=0, inst_valid=0, outputs 0.
   - After release, fetch restarts at RESET_PC.
